sw_input_conditioner: RTL

//   Conditions the 8 raw slide-switch inputs before they reach the LED-effect

---
 rtl/sw_input_conditioner.sv | 90 +++++++++
 1 files changed

// File: rtl/sw_input_conditioner.sv
// Switch input conditioner: per-bit 2-flop sync + stable-count debounce.
// Ports: clk, reset (async active-low), sw_raw in; sw_clean, sw_changed, sw_valid out.
module sw_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic             sw_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int ST_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [ST_W-1:0] ST_END =
    ST_W'(DEBOUNCE_CYCLES + 2);

  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            s2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            clean_q;
  logic [WIDTH-1:0]            clean_d;
  logic                        changed_q;
  logic                        changed_d;
  logic                        valid_q;
  logic                        valid_d;
  logic [ST_W-1:0]             st_q;
  logic [ST_W-1:0]             st_d;

  // Counter tracks how long s2 has disagreed with the accepted level.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Startup timer freezes once valid is reached.
  always_comb begin
    st_d    = st_q;
    valid_d = valid_q;
    if (!valid_q) begin
      st_d    = st_q + ST_W'(1);
      valid_d = (st_d == ST_END);
    end
  end

  // Power-on settling updates are not reported as changes.
  always_comb begin
    changed_d = valid_q && (clean_d != clean_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      changed_q <= 1'b0;
      valid_q   <= 1'b0;
      st_q      <= '0;
    end else begin
      s1_q      <= sw_raw;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
      st_q      <= st_d;
    end
  end

  assign sw_clean   = clean_q;
  assign sw_changed = changed_q;
  assign sw_valid   = valid_q;

endmodule
